// File: rtl/mult_div_unit_if.sv
// Request/response bus between the datapath and the multiply/divide unit.
// The datapath is the master; the unit owning HI/LO is the slave.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 sequential MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Define MDU_EARLY_OUT_EN to end multiplies once the multiplier is exhausted.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t             state;
    state_t             state_n;
    logic [CW-1:0]      cnt;
    logic               is_mul;
    logic               neg_a;
    logic               neg_b;
    logic               b_zero;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;
    logic               div_zero;

    logic               sgn_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               early;
    logic               last;
    logic               accept;
    logic               do_iter;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

`ifdef MDU_EARLY_OUT_EN
    assign early = is_mul && (mplier == '0);
`else
    assign early = 1'b0;
`endif

    always_comb begin
        sgn_in   = ~bus.op[0];
        mag_a    = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b    = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        accept   = (state == IDLE) && bus.start;
        last     = (cnt == CW'(1)) || early;
        do_iter  = (state == CALC) && !early;
        // Restoring step: top bit of diff is the borrow.
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        prod_res = (neg_a ^ neg_b) ? -prod : prod;
        quo_res  = (neg_a ^ neg_b) ? -quo : quo;
        rem_res  = neg_a ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = CALC;
            CALC:    if (last) state_n = SIGN;
            SIGN:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            is_mul   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            b_zero   <= 1'b0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                is_mul <= ~bus.op[1];
                neg_a  <= sgn_in & bus.a[WIDTH-1];
                neg_b  <= sgn_in & bus.b[WIDTH-1];
                b_zero <= (bus.b == '0);
                prod   <= '0;
                mcand  <= {{WIDTH{1'b0}}, mag_a};
                mplier <= mag_b;
                quo    <= mag_a;
                rem    <= '0;
                dvs    <= mag_b;
                cnt    <= CW'(WIDTH);
            end else if (state == IDLE) begin
                if (bus.mthi) hi <= bus.wdata;
                if (bus.mtlo) lo <= bus.wdata;
            end
            if (do_iter) begin
                cnt <= cnt - CW'(1);
                if (is_mul) begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end else if (!diff[WIDTH]) begin
                    rem <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end
            if (state == SIGN) begin
                done <= 1'b1;
                if (is_mul) begin
                    {hi, lo} <= prod_res;
                end else begin
                    div_zero <= b_zero;
                    // Divide by zero: remainder holds the dividend unchanged.
                    hi <= rem_res;
                    lo <= b_zero ? '1 : quo_res;
                end
            end
        end
    end

    assign bus.hi       = hi;
    assign bus.lo       = lo;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done;
    assign bus.div_zero = div_zero;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a reference model pushes expected
// HI/LO/div_zero/latency on issue, each test pops and compares on done.
module tb_mult_div_unit;
    logic clk;
    logic rst;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic        dz_model = 1'b0;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;

    task automatic push_exp(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        logic [31:0] m;
        int          n;
        e.lat = 33;
        case (op)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {e.hi, e.lo} = p;
            end
            2'd1: begin
                u = {32'd0, a} * {32'd0, b};
                {e.hi, e.lo} = u;
            end
            2'd2: begin
                dz_model = (b == 32'd0);
                if (b == 32'd0) begin
                    e.lo = 32'hFFFFFFFF;
                    e.hi = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.lo = 32'h80000000;
                    e.hi = 32'd0;
                end else begin
                    e.lo = 32'($signed(a) / $signed(b));
                    e.hi = 32'($signed(a) % $signed(b));
                end
            end
            default: begin
                dz_model = (b == 32'd0);
                if (b == 32'd0) begin
                    e.lo = 32'hFFFFFFFF;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        e.dz = dz_model;
`ifdef MDU_EARLY_OUT_EN
        if (op[1] == 1'b0) begin
            m = (op == 2'd0 && b[31]) ? -b : b;
            n = 0;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
            e.lat = (n + 2 < 33) ? n + 2 : 33;
        end
`else
        m = b;
        n = 0;
`endif
        sb.push_back(e);
    endtask

    // Called #1 after an edge; returns #1 after start edge 0.
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic with_mt);
        push_exp(op, a, b);
        pre_hi    = bus.hi;
        pre_lo    = bus.lo;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (with_mt) begin
            bus.mthi  = 1'b1;
            bus.mtlo  = 1'b1;
            bus.wdata = 32'h55;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic collect(input int disturb, output logic [31:0] h,
                           output logic [31:0] l, output logic dz,
                           output int lat, output int busy_n,
                           output logic held);
        lat    = -1;
        busy_n = 0;
        held   = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.busy) busy_n++;
            if (bus.busy && (bus.hi !== pre_hi || bus.lo !== pre_lo))
                held = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (k == disturb) begin
                bus.start = 1'b1;
                bus.op    = 2'b11;
                bus.a     = 32'd99;
                bus.b     = 32'd1;
                bus.mthi  = 1'b1;
                bus.wdata = 32'hAA;
            end else if (k == disturb + 1) begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
            end
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        h  = bus.hi;
        l  = bus.lo;
        dz = bus.div_zero;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_hilo got %h/%h want 0/0", bus.hi, bus.lo);
        end
        checks++;
        if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.busy, bus.done, bus.div_zero});
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mult;
        logic [1:0]  ops[6] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
        logic [31:0] as[6]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000,
                                32'd7, 32'd5, 32'd0};
        logic [31:0] bs[6]  = '{32'd3, 32'hFFFFFFFF, 32'h80000000,
                                32'hFFFFFFFB, 32'd1, 32'd9};
        logic [31:0] h, l;
        logic        dz, held;
        int          lat, bn;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 1'b0);
            collect(-1, h, l, dz, lat, bn, held);
            e = sb.pop_front();
            checks++;
            if (h !== e.hi || l !== e.lo) begin
                failures++;
                $display("FAIL mult[%0d] got %h_%h want %h_%h",
                         i, h, l, e.hi, e.lo);
            end
            checks++;
            if (lat !== e.lat || bn !== e.lat) begin
                failures++;
                $display("FAIL mult_lat[%0d] got lat=%0d busy=%0d want %0d",
                         i, lat, bn, e.lat);
            end
            checks++;
            if (!held) begin
                failures++;
                $display("FAIL mult_hold[%0d] got changed want held", i);
            end
        end
    endtask

    task automatic test_div;
        logic [1:0]  ops[5] = '{2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
        logic [31:0] as[5]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000,
                                32'd100, 32'hFFFFFFFF};
        logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFFFFFF,
                                32'hFFFFFFF9, 32'd3};
        logic [31:0] h, l;
        logic        dz, held;
        int          lat, bn;
        exp_t        e;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], 1'b0);
            collect(-1, h, l, dz, lat, bn, held);
            e = sb.pop_front();
            checks++;
            if (h !== e.hi || l !== e.lo || dz !== e.dz) begin
                failures++;
                $display("FAIL div[%0d] got %h_%h dz=%b want %h_%h dz=%b",
                         i, h, l, dz, e.hi, e.lo, e.dz);
            end
            checks++;
            if (lat !== e.lat) begin
                failures++;
                $display("FAIL div_lat[%0d] got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [1:0]  ops[4] = '{2'd3, 2'd0, 2'd2, 2'd2};
        logic [31:0] as[4]  = '{32'h1234, 32'd3, 32'd6, 32'hFFFFFFFB};
        logic [31:0] bs[4]  = '{32'd0, 32'd4, 32'd3, 32'd0};
        logic [31:0] h, l;
        logic        dz, held;
        int          lat, bn;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 1'b0);
            collect(-1, h, l, dz, lat, bn, held);
            e = sb.pop_front();
            checks++;
            if (h !== e.hi || l !== e.lo || dz !== e.dz || lat !== e.lat) begin
                failures++;
                $display("FAIL divzero[%0d] got %h_%h dz=%b lat=%0d want %h_%h dz=%b lat=%0d",
                         i, h, l, dz, lat, e.hi, e.lo, e.dz, e.lat);
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] h, l;
        logic        dz, held;
        int          lat, bn, extra;
        exp_t        e;
        issue(2'd0, 32'd5, 32'd7, 1'b0);
        collect(5, h, l, dz, lat, bn, held);
        e = sb.pop_front();
        checks++;
        if (h !== e.hi || l !== e.lo || lat !== e.lat || !held) begin
            failures++;
            $display("FAIL busy_ignore got %h_%h lat=%0d held=%b want %h_%h lat=%0d held=1",
                     h, l, lat, held, e.hi, e.lo, e.lat);
        end
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL busy_single got %0d extra active cycles want 0", extra);
        end
        bus.mthi  = 1'b1;
        bus.wdata = 32'hAA;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        checks++;
        if (bus.hi !== 32'hAA || bus.lo !== e.lo) begin
            failures++;
            $display("FAIL mthi got %h/%h want %h/%h", bus.hi, bus.lo, 32'hAA, e.lo);
        end
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h77;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        checks++;
        if (bus.hi !== 32'h77 || bus.lo !== 32'h77) begin
            failures++;
            $display("FAIL mthi_mtlo got %h/%h want 77/77", bus.hi, bus.lo);
        end
        issue(2'd3, 32'd100, 32'd7, 1'b1);
        collect(-1, h, l, dz, lat, bn, held);
        e = sb.pop_front();
        checks++;
        if (h !== e.hi || l !== e.lo || !held) begin
            failures++;
            $display("FAIL mt_with_start got %h_%h held=%b want %h_%h held=1",
                     h, l, held, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] h, l;
        logic        dz, held;
        int          lat, bn, seen;
        exp_t        e;
        issue(2'd3, 32'd9, 32'd0, 1'b0);
        collect(-1, h, l, dz, lat, bn, held);
        e = sb.pop_front();
        checks++;
        if (h !== e.hi || l !== e.lo || dz !== e.dz) begin
            failures++;
            $display("FAIL pre_abort got %h_%h dz=%b want %h_%h dz=%b",
                     h, l, dz, e.hi, e.lo, e.dz);
        end
        issue(2'd0, 32'd12345, 32'd678, 1'b0);
        void'(sb.pop_back());
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        dz_model = 1'b0;
        #1;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 ||
            bus.div_zero !== 1'b0) begin
            failures++;
            $display("FAIL abort got %h/%h busy=%b dz=%b want 0/0 busy=0 dz=0",
                     bus.hi, bus.lo, bus.busy, bus.div_zero);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL abort_nodone got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] h, l, a, b;
        logic [1:0]  op;
        logic        dz, held;
        int          lat, bn;
        exp_t        e;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 5 == 4) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            issue(op, a, b, 1'b0);
            collect(-1, h, l, dz, lat, bn, held);
            e = sb.pop_front();
            checks++;
            if (h !== e.hi || l !== e.lo || dz !== e.dz || lat !== e.lat) begin
                failures++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h got %h_%h dz=%b lat=%0d want %h_%h dz=%b lat=%0d",
                         i, op, a, b, h, l, dz, lat, e.hi, e.lo, e.dz, e.lat);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO pair; it is the responder side of the CPU's MULT/DIV/MFHI/MFLO/MTHI/MTLO path.
- The datapath issues an operation with a start pulse, observes busy/done, and reads HI/LO.
- Replaces single-cycle combinational multiply/divide with a radix-2 sequential engine: shift-add for multiply, restoring division for divide.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count is WIDTH.

Ports:
iCLK  in  1  clock, all state on rising edge
iRST  in  1  reset, asynchronous, active-high
iStart  in  1  request pulse; sampled only in IDLE
iOp  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
iA  in  WIDTH  rs operand: multiplicand or dividend
iB  in  WIDTH  rt operand: multiplier or divisor
iMTHI  in  1  write iWData to HI
iMTLO  in  1  write iWData to LO
iWData  in  WIDTH  MTHI/MTLO data
oHI  out  WIDTH  HI register
oLO  out  WIDTH  LO register
oBusy  out  1  operation in progress
oDone  out  1  one-cycle completion pulse
oDivZero  out  1  last completed divide had divisor 0

Behaviour:
- Reset (async, any state): HI=0, LO=0, state IDLE, oBusy=0, oDone=0, oDivZero=0, counter=0.
- States: IDLE, CALC, SIGN.
- IDLE:
  - iStart=1 at edge 0: latch op, signs of iA/iB, and magnitudes (|x| for signed ops, raw for unsigned). Load counter=WIDTH. Go to CALC.
  - oBusy=1 from edge 0 until edge WIDTH+1.
- CALC: one iteration per edge; counter decrements; leave to SIGN when counter reaches 0 (after edge WIDTH).
  - MULT: 2*WIDTH product accumulator, shift-add on multiplier LSB.
  - DIV: restoring. Shift remainder left with next dividend bit; subtract divisor if no borrow; quotient bit = !borrow.
- SIGN, at edge WIDTH+1:
  - Multiply: {HI,LO} = product, two's-complement negated if signed and sign(A)^sign(B).
  - Divide: LO = quotient, negated if signed and signs differ. HI = remainder, negated if signed and A negative.
  - oDone=1 for the following cycle only. oBusy=0. Return to IDLE.
  - Default latency: HI/LO valid and oDone high in the cycle after edge WIDTH+1 (33 edges after start for WIDTH=32).
- Unsigned multiply uses unsigned magnitudes; MULTU of 0xFFFFFFFF*0xFFFFFFFF is exact.
- Divide by zero (iB=0): normal latency; LO=all ones, HI=iA unchanged; oDivZero=1 (held until next divide completes).
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no flag.
- Operand registers are latched at start; iA/iB changes during busy have no effect.
- iStart while oBusy=1: ignored; no queueing.
- iMTHI/iMTLO:
  - In IDLE, and not coincident with iStart: write at the edge; both may assert together.
  - While busy, or when coincident with an accepted iStart: ignored.
  - In the SIGN cycle the result write wins.
- oHI/oLO always show the committed registers; they are not updated mid-operation (partial results stay internal).
- Reset mid-operation aborts; no oDone.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: multiply terminates when the remaining multiplier magnitude is zero, checked on each CALC cycle before iterating. Completion edge = n+2, where n is the count of significant bits of the multiplier magnitude (n=0 for 0). Divide latency is unchanged.
- Undefined: fixed WIDTH+1-edge latency for all operations.
- Results are identical in both builds.

Test Plan:
- MULT iA=0xFFFFFFFE (-2), iB=3 -> oDone 33 edges after start; HI=0xFFFFFFFF, LO=0xFFFFFFFA; oBusy high for exactly 33 cycles.
- MULTU iA=iB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV iA=-7 (0xFFFFFFF9), iB=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/2 -> LO=3, HI=1.
- DIVU iA=0x1234, iB=0 -> LO=0xFFFFFFFF, HI=0x1234, oDivZero=1. A following DIV 6/3 clears oDivZero.
- Second iStart and iMTHI=1 (iWData=0xAA) issued during busy -> both ignored, single oDone; then idle MTHI 0xAA -> HI=0xAA next edge.
- iRST asserted mid-CALC -> HI=LO=0, oBusy=0 immediately (async), no oDone. With MDU_EARLY_OUT_EN: MULT 5*1 -> oDone after edge 3.
